// File: rtl/usb_dfu_reboot_ctrl_if.sv
// ---------------------------------------------------------------------------
// usb_dfu_reboot_ctrl_if
//   Groups the DFU status inputs and the reboot/pull-up control outputs of
//   usb_dfu_reboot_ctrl into one bundle.
//
//   Signals
//     dfu_detach      1  level, high once the host has issued DFU_DETACH
//     dfu_state       8  DFU state code from usb_dfu_core
//     usb_reset       1  level, high while bus reset (long SE0) is seen
//     usb_pullup_en   1  1 = D+ pull-up enabled (device attached)
//     reboot_pending  1  high while a reboot is being sequenced
//     boot            1  warmboot trigger, latched
//     boot_image      2  warmboot image select, valid when boot=1
//
//   Modports
//     master  side that supplies DFU status and consumes the controls
//     slave   the reboot controller itself
// ---------------------------------------------------------------------------
interface usb_dfu_reboot_ctrl_if;
  logic       dfu_detach;
  logic [7:0] dfu_state;
  logic       usb_reset;
  logic       usb_pullup_en;
  logic       reboot_pending;
  logic       boot;
  logic [1:0] boot_image;

  modport master (
    output dfu_detach,
    output dfu_state,
    output usb_reset,
    input  usb_pullup_en,
    input  reboot_pending,
    input  boot,
    input  boot_image
  );

  modport slave (
    input  dfu_detach,
    input  dfu_state,
    input  usb_reset,
    output usb_pullup_en,
    output reboot_pending,
    output boot,
    output boot_image
  );
endinterface

// File: rtl/usb_dfu_reboot_ctrl.sv
// ---------------------------------------------------------------------------
// usb_dfu_reboot_ctrl
//   Sequences the exit from the DFU bootloader: wait for a bus reset (or the
//   detach timeout), drop the D+ pull-up so the host sees a disconnect, then
//   raise a latched warmboot request selecting the application image.
//
//   Ports
//     clk_i    in   1  system clock, all logic on posedge
//     reset_i  in   1  synchronous, active-high
//     bus_if   slave modport of usb_dfu_reboot_ctrl_if (DFU status in,
//              pull-up / warmboot controls out)
//
//   State table
//     state          | meaning
//     ST_IDLE        | bootloader running, pull-up on, no reboot requested
//     ST_ARMED       | detach seen, waiting for bus reset or timeout
//     ST_DISCONNECT  | pull-up off for DISCONNECT_CYCLES clocks
//     ST_BOOT        | warmboot asserted, terminal until reset
// ---------------------------------------------------------------------------
module usb_dfu_reboot_ctrl #(
  parameter int unsigned TICKS_PER_MS      = 48000,
  parameter int unsigned DETACH_TIMEOUT_MS = 255,
  parameter int unsigned DISCONNECT_CYCLES = 480000,
  parameter logic [1:0]  APP_IMAGE         = 2'd1
) (
  input logic                  clk_i,
  input logic                  reset_i,
  usb_dfu_reboot_ctrl_if.slave bus_if
);

  localparam int TICK_W = $clog2(TICKS_PER_MS + 1);
  localparam int MS_W   = $clog2(DETACH_TIMEOUT_MS + 1);
  localparam int DISC_W = $clog2(DISCONNECT_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(DETACH_TIMEOUT_MS - 1);
  localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(DISCONNECT_CYCLES - 1);

  localparam logic [7:0] DFU_MANIFEST_WAIT_RESET = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ARMED      = 2'd1,
    ST_DISCONNECT = 2'd2,
    ST_BOOT       = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic [DISC_W-1:0] disc_cnt_q, disc_cnt_d;

  logic       pullup_q, pullup_d;
  logic       pending_q, pending_d;
  logic       boot_q, boot_d;
  logic [1:0] image_q, image_d;

  logic manifest_reset;
  logic tick_wrap;
  logic timeout_hit;

  assign manifest_reset = (bus_if.dfu_state == DFU_MANIFEST_WAIT_RESET) && bus_if.usb_reset;
  assign tick_wrap      = (tick_cnt_q == TICK_LAST);
  // Leave ARMED on the very edge at which ms_cnt would reach the timeout, so
  // the ARMED dwell is exactly DETACH_TIMEOUT_MS * TICKS_PER_MS cycles.
  assign timeout_hit    = tick_wrap && (ms_cnt_q == MS_LAST);

  always_comb begin
    state_d    = state_q;
    // Counters idle at zero outside their own state, which clears them on entry.
    tick_cnt_d = '0;
    ms_cnt_d   = '0;
    disc_cnt_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Manifest path has priority over a simultaneous detach.
        if (manifest_reset) begin
          state_d = ST_DISCONNECT;
        end else if (bus_if.dfu_detach) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (tick_wrap) begin
          tick_cnt_d = '0;
          ms_cnt_d   = ms_cnt_q + MS_W'(1);
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          ms_cnt_d   = ms_cnt_q;
        end
        if (bus_if.usb_reset || timeout_hit) begin
          state_d = ST_DISCONNECT;
        end
      end
      ST_DISCONNECT: begin
        disc_cnt_d = disc_cnt_q + DISC_W'(1);
        if (disc_cnt_q == DISC_LAST) begin
          state_d = ST_BOOT;
        end
      end
      ST_BOOT: begin
        state_d = ST_BOOT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they track the state
    // register without an extra cycle of lag.
    pullup_d  = (state_d == ST_IDLE) || (state_d == ST_ARMED);
    pending_d = (state_d == ST_ARMED) || (state_d == ST_DISCONNECT);
    boot_d    = (state_d == ST_BOOT);
    image_d   = (state_d == ST_BOOT) ? APP_IMAGE : 2'd0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      ms_cnt_q   <= '0;
      disc_cnt_q <= '0;
      pullup_q   <= 1'b1;
      pending_q  <= 1'b0;
      boot_q     <= 1'b0;
      image_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      pullup_q   <= pullup_d;
      pending_q  <= pending_d;
      boot_q     <= boot_d;
      image_q    <= image_d;
    end
  end

  assign bus_if.usb_pullup_en  = pullup_q;
  assign bus_if.reboot_pending = pending_q;
  assign bus_if.boot           = boot_q;
  assign bus_if.boot_image     = image_q;

endmodule
